// File: rtl/cache_miss_ctrl_pkg.sv
// Shared types for the cache miss sequencer: controller state encoding and
// a small helper for recognising the memory-burst states.
package cache_miss_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOOKUP = 3'd1,
        ST_WB     = 3'd2,
        ST_FILL   = 3'd3,
        ST_UPDATE = 3'd4
    } state_t;

    localparam int TAG_WIDTH_DEF    = 8;
    localparam int INDEX_WIDTH_DEF  = 4;
    localparam int OFFSET_WIDTH_DEF = 4;
    localparam int CHAN_WIDTH_DEF   = 3;

    function automatic logic is_burst(input state_t s);
        return (s == ST_WB) || (s == ST_FILL);
    endfunction

endpackage

// File: rtl/cache_miss_ctrl_burst_counter.sv
// Beat counter for writeback/fill bursts: clears at lookup, advances on each
// accepted beat, and flags the final beat of the line.
module burst_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             advance,
    output logic [WIDTH-1:0] beat,
    output logic             last
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat <= '0;
        end else if (clear) begin
            beat <= '0;
        end else if (advance) begin
            beat <= beat + 1'b1;
        end
    end

    assign last = &beat;

endmodule

// File: rtl/cache_miss_ctrl.sv
// Request sequencer in front of TagMemory: lookup, dirty-victim writeback,
// line fill, tag install, then replay so every acknowledged access is a hit.
//
//  state  | meaning
//  IDLE   | waiting for cpu_req (ignored during the ack cycle)
//  LOOKUP | tag compare; hit acks next cycle, miss latches victim
//  WB     | writing back the dirty victim line, one beat per mem_ack
//  FILL   | fetching the requested line into the victim way
//  UPDATE | TagMemory installs the new tag into the LRU way
module cache_miss_ctrl
    import cache_miss_ctrl_pkg::*;
#(
    parameter int TAG_WIDTH    = 8,
    parameter int INDEX_WIDTH  = 4,
    parameter int OFFSET_WIDTH = 4,
    parameter int CHAN_WIDTH   = 3
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic                                        cpu_req,
    input  logic                                        cpu_we,
    input  logic [TAG_WIDTH+INDEX_WIDTH+OFFSET_WIDTH-1:0] cpu_addr,
    output logic                                        cpu_ack,
    output logic [TAG_WIDTH-1:0]                        tm_tag,
    output logic [INDEX_WIDTH-1:0]                      tm_index,
    output logic                                        tm_wr,
    output logic                                        tm_mod_in,
    output logic                                        tm_age,
    input  logic                                        tm_hit,
    input  logic [CHAN_WIDTH-1:0]                       tm_chan,
    input  logic [CHAN_WIDTH-1:0]                       tm_age_chan,
    input  logic [TAG_WIDTH-1:0]                        tm_age_tag,
    input  logic                                        tm_age_mod,
    input  logic                                        tm_age_valid,
    output logic                                        mem_req,
    output logic                                        mem_we,
    output logic [TAG_WIDTH+INDEX_WIDTH+OFFSET_WIDTH-1:0] mem_addr,
    input  logic                                        mem_ack,
    output logic [CHAN_WIDTH-1:0]                       da_chan,
    output logic [OFFSET_WIDTH-1:0]                     da_offset,
    output logic                                        da_fill_we
);

    localparam int ADDR_WIDTH = TAG_WIDTH + INDEX_WIDTH + OFFSET_WIDTH;

    state_t                  state;
    logic [TAG_WIDTH-1:0]    req_tag;
    logic [INDEX_WIDTH-1:0]  req_index;
    logic [OFFSET_WIDTH-1:0] req_offset;
    logic                    req_we;
    logic [TAG_WIDTH-1:0]    victim_tag;
    logic [CHAN_WIDTH-1:0]   victim_chan;
    logic [CHAN_WIDTH-1:0]   hit_chan;
    logic [OFFSET_WIDTH-1:0] hit_offset;

    logic                    in_burst;
    logic                    beat_clear;
    logic                    beat_advance;
    logic [OFFSET_WIDTH-1:0] beat;
    logic                    last_beat;

    assign in_burst     = is_burst(state);
    assign beat_clear   = (state == ST_LOOKUP);
    assign beat_advance = mem_ack && in_burst;

    burst_counter #(
        .WIDTH(OFFSET_WIDTH)
    ) u_burst_counter (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (beat_clear),
        .advance(beat_advance),
        .beat   (beat),
        .last   (last_beat)
    );

    assign tm_tag     = req_tag;
    assign tm_index   = req_index;
    assign mem_addr   = mem_req ? {((state == ST_WB) ? victim_tag : req_tag), req_index, beat}
                                : {ADDR_WIDTH{1'b0}};
    assign da_chan    = in_burst ? victim_chan : hit_chan;
    assign da_offset  = in_burst ? beat : hit_offset;
    assign da_fill_we = mem_ack && (state == ST_FILL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            req_tag     <= '0;
            req_index   <= '0;
            req_offset  <= '0;
            req_we      <= 1'b0;
            victim_tag  <= '0;
            victim_chan <= '0;
            hit_chan    <= '0;
            hit_offset  <= '0;
            cpu_ack     <= 1'b0;
            tm_wr       <= 1'b0;
            tm_mod_in   <= 1'b0;
            tm_age      <= 1'b0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
        end else begin
            cpu_ack    <= 1'b0;
            tm_wr      <= 1'b0;
            tm_mod_in  <= 1'b0;
            tm_age     <= 1'b0;
            hit_chan   <= '0;
            hit_offset <= '0;
            case (state)
                ST_IDLE: begin
                    // cpu_req is still high for the request being acked; skip it
                    if (cpu_req && !cpu_ack) begin
                        req_tag    <= cpu_addr[ADDR_WIDTH-1 -: TAG_WIDTH];
                        req_index  <= cpu_addr[OFFSET_WIDTH +: INDEX_WIDTH];
                        req_offset <= cpu_addr[OFFSET_WIDTH-1:0];
                        req_we     <= cpu_we;
                        state      <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    if (tm_hit) begin
                        cpu_ack    <= 1'b1;
                        tm_age     <= 1'b1;
                        tm_wr      <= req_we;
                        tm_mod_in  <= req_we;
                        hit_chan   <= tm_chan;
                        hit_offset <= req_offset;
                        state      <= ST_IDLE;
                    end else begin
                        victim_chan <= tm_age_chan;
                        victim_tag  <= tm_age_tag;
                        mem_req     <= 1'b1;
                        if (tm_age_valid && tm_age_mod) begin
                            mem_we <= 1'b1;
                            state  <= ST_WB;
                        end else begin
                            mem_we <= 1'b0;
                            state  <= ST_FILL;
                        end
                    end
                end
                ST_WB: begin
                    if (mem_ack && last_beat) begin
                        mem_we <= 1'b0;
                        state  <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (mem_ack && last_beat) begin
                        mem_req <= 1'b0;
                        tm_wr   <= 1'b1;
                        state   <= ST_UPDATE;
                    end
                end
                ST_UPDATE: begin
                    state <= ST_LOOKUP;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// Scoreboard bench for cache_miss_ctrl: a TagMemory/memory environment plus a
// transaction-level cache model that predicts every beat and acknowledge.
module tb_cache_miss_ctrl;

    localparam int TW = 8;
    localparam int IW = 4;
    localparam int OW = 4;
    localparam int CW = 3;
    localparam int AW = TW + IW + OW;
    localparam int NW = 8;
    localparam int NS = 16;
    localparam int BEATS = 16;

    logic          clk;
    logic          rst_n;
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic          cpu_ack;
    logic [TW-1:0] tm_tag;
    logic [IW-1:0] tm_index;
    logic          tm_wr;
    logic          tm_mod_in;
    logic          tm_age;
    logic          tm_hit;
    logic [CW-1:0] tm_chan;
    logic [CW-1:0] tm_age_chan;
    logic [TW-1:0] tm_age_tag;
    logic          tm_age_mod;
    logic          tm_age_valid;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic          mem_ack;
    logic [CW-1:0] da_chan;
    logic [OW-1:0] da_offset;
    logic          da_fill_we;

    cache_miss_ctrl #(
        .TAG_WIDTH(TW), .INDEX_WIDTH(IW), .OFFSET_WIDTH(OW), .CHAN_WIDTH(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_ack(cpu_ack),
        .tm_tag(tm_tag), .tm_index(tm_index), .tm_wr(tm_wr), .tm_mod_in(tm_mod_in),
        .tm_age(tm_age), .tm_hit(tm_hit), .tm_chan(tm_chan), .tm_age_chan(tm_age_chan),
        .tm_age_tag(tm_age_tag), .tm_age_mod(tm_age_mod), .tm_age_valid(tm_age_valid),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_ack(mem_ack),
        .da_chan(da_chan), .da_offset(da_offset), .da_fill_we(da_fill_we)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // TagMemory environment: recency is a per-way timestamp, victim is the
    // lowest invalid way, else the oldest timestamp.
    logic [TW-1:0] env_tag   [NS][NW] = '{default: '0};
    logic          env_val   [NS][NW] = '{default: 1'b0};
    logic          env_mod   [NS][NW] = '{default: 1'b0};
    int            env_stamp [NS][NW] = '{default: 0};
    int            cyc = 0;
    logic          env_inv;
    int            env_best;

    always_comb begin
        tm_hit   = 1'b0;
        tm_chan  = '0;
        env_inv  = 1'b0;
        env_best = 0;
        for (int w = 0; w < NW; w++)
            if (!tm_hit && env_val[tm_index][w] && env_tag[tm_index][w] == tm_tag) begin
                tm_hit  = 1'b1;
                tm_chan = CW'(w);
            end
        for (int w = 0; w < NW; w++)
            if (!env_inv && !env_val[tm_index][w]) begin
                env_inv  = 1'b1;
                env_best = w;
            end
        if (!env_inv)
            for (int w = 1; w < NW; w++)
                if (env_stamp[tm_index][w] < env_stamp[tm_index][env_best]) env_best = w;
        tm_age_chan  = CW'(env_best);
        tm_age_tag   = env_tag[tm_index][env_best];
        tm_age_mod   = env_mod[tm_index][env_best];
        tm_age_valid = env_val[tm_index][env_best];
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (tm_age && tm_hit) begin
            env_stamp[tm_index][tm_chan] <= cyc + 1;
            if (tm_wr && tm_mod_in) env_mod[tm_index][tm_chan] <= 1'b1;
        end else if (tm_wr && !tm_age) begin
            env_tag[tm_index][tm_age_chan] <= tm_tag;
            env_val[tm_index][tm_age_chan] <= 1'b1;
            env_mod[tm_index][tm_age_chan] <= tm_mod_in;
        end
    end

    // Reference cache: per set an LRU-ordered list of ways (front = victim).
    logic [TW-1:0] ref_tag   [NS][NW];
    bit            ref_val   [NS][NW];
    bit            ref_dirty [NS][NW];
    int            ref_order [NS][$];

    typedef struct {
        int            kind;   // 0 writeback beat, 1 fill beat, 2 acknowledge
        logic [AW-1:0] addr;
        int            chan;
        int            offset;
        bit            we;
    } exp_t;
    exp_t exp_q[$];

    task automatic ref_access(input logic [AW-1:0] a, input bit we, input bit commit,
                              output bit hit, output bit dirty_miss);
        logic [TW-1:0] t;
        int idx, off, way, pos;
        t   = a[AW-1 -: TW];
        idx = int'(a[OW +: IW]);
        off = int'(a[OW-1:0]);
        way = -1;
        dirty_miss = 1'b0;
        for (int w = 0; w < NW; w++)
            if (way < 0 && ref_val[idx][w] && ref_tag[idx][w] == t) way = w;
        hit = (way >= 0);
        if (!hit) begin
            way = ref_order[idx][0];
            dirty_miss = ref_val[idx][way] && ref_dirty[idx][way];
            if (dirty_miss)
                for (int b = 0; b < BEATS; b++)
                    exp_q.push_back('{0, {ref_tag[idx][way], IW'(idx), OW'(b)}, way, b, 1'b1});
            for (int b = 0; b < BEATS; b++)
                exp_q.push_back('{1, {t, IW'(idx), OW'(b)}, way, b, 1'b0});
        end
        exp_q.push_back('{2, a, way, off, we});
        if (commit) begin
            if (!hit) begin
                ref_tag[idx][way]   = t;
                ref_val[idx][way]   = 1'b1;
                ref_dirty[idx][way] = 1'b0;
            end
            pos = 0;
            for (int i = 0; i < ref_order[idx].size(); i++)
                if (ref_order[idx][i] == way) pos = i;
            ref_order[idx].delete(pos);
            ref_order[idx].push_back(way);
            if (we) ref_dirty[idx][way] = 1'b1;
        end
    endtask

    // Memory responder: stalls each beat, checks the beat is held, and
    // throws in stray acks while no burst is active.
    int   stall_fixed = 0;
    int   stall_left = 0;
    bit   fresh = 1'b1;
    logic [AW-1:0] held_addr;
    logic held_we;

    initial begin
        mem_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (!mem_req) begin
                mem_ack = ($urandom_range(0, 3) == 0);
                fresh = 1'b1;
            end else begin
                if (fresh) begin
                    held_addr  = mem_addr;
                    held_we    = mem_we;
                    stall_left = (stall_fixed >= 0) ? stall_fixed : int'($urandom_range(0, 2));
                    fresh = 1'b0;
                end else begin
                    check("mem_addr held", mem_addr, held_addr);
                    check("mem_we held", mem_we, held_we);
                end
                if (stall_left == 0) begin
                    mem_ack = 1'b1;
                    fresh = 1'b1;
                end else begin
                    mem_ack = 1'b0;
                    stall_left--;
                end
            end
        end
    end

    // Monitor: every accepted beat and every acknowledge pops one expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n) begin
                if (mem_req && mem_ack) begin
                    check("expectation pending at beat", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("beat kind", mem_we ? 0 : 1, e.kind);
                        check("mem_addr", mem_addr, e.addr);
                        check("burst da_chan", da_chan, e.chan);
                        check("burst da_offset", da_offset, e.offset);
                        check("da_fill_we", da_fill_we, e.kind == 1);
                    end
                end
                if (cpu_ack) begin
                    check("expectation pending at ack", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("ack kind", e.kind, 2);
                        check("ack da_chan", da_chan, e.chan);
                        check("ack da_offset", da_offset, e.offset);
                        check("ack tm_wr", tm_wr, e.we);
                        check("ack tm_mod_in", tm_mod_in, e.we);
                        check("ack tm_age", tm_age, 1);
                    end
                end
                if (tm_age) check("tm_age only with ack", cpu_ack, 1);
                if (tm_wr && !tm_age) check("install tm_mod_in", tm_mod_in, 0);
            end
        end
    end

    task automatic do_req(input logic [AW-1:0] a, input bit we, input int gap);
        bit hit, dm, done;
        int lat, exp_lat;
        for (int g = 0; g < gap; g++) @(negedge clk);
        cpu_addr = a;
        cpu_we   = we;
        cpu_req  = 1'b1;
        ref_access(a, we, 1'b1, hit, dm);
        exp_lat = -1;
        if (hit)
            exp_lat = 2 + ((gap == 0) ? 1 : 0);
        else if (stall_fixed >= 0)
            exp_lat = 4 + (dm ? 2 * BEATS : BEATS) * (stall_fixed + 1) + ((gap == 0) ? 1 : 0);
        done = 1'b0;
        lat = 0;
        while (!done && lat < 2000) begin
            @(negedge clk);
            lat++;
            if (cpu_ack) done = 1'b1;
        end
        check("ack within budget", done, 1);
        if (done && exp_lat >= 0) check("req to ack latency", lat, exp_lat);
        cpu_req = 1'b0;
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit hit, dm, seen;
        int n;
        logic [TW-1:0] t;
        for (int s = 0; s < NS; s++) begin
            for (int w = 0; w < NW; w++) begin
                ref_tag[s][w] = '0;
                ref_val[s][w] = 1'b0;
                ref_dirty[s][w] = 1'b0;
                ref_order[s].push_back(w);
            end
        end
        rst_n = 1'b0;
        cpu_req = 1'b0;
        cpu_we = 1'b0;
        cpu_addr = '0;
        repeat (3) @(negedge clk);
        check("reset cpu_ack", cpu_ack, 0);
        check("reset mem_req", mem_req, 0);
        check("reset mem_addr", mem_addr, 0);
        check("reset tm_wr", tm_wr, 0);
        check("reset tm_age", tm_age, 0);
        check("reset tm_tag", tm_tag, 0);
        check("reset da_fill_we", da_fill_we, 0);
        check("reset da_chan", da_chan, 0);
        #3 rst_n = 1'b1;

        stall_fixed = 0;
        do_req(16'h1234, 1'b0, 2);               // cold miss, clean fill
        do_req(16'h1234, 1'b0, 1);               // hit
        @(negedge clk);
        check("tm_age single cycle", tm_age, 0);
        check("cpu_ack single cycle", cpu_ack, 0);
        do_req(16'h1235, 1'b1, 1);               // write hit marks way 0 dirty
        for (int i = 0; i < 7; i++) do_req({8'(8'h20 + i), 8'h30}, 1'b0, 1);
        do_req(16'h2730, 1'b0, 1);               // evicts dirty way 0 with writeback
        do_req(16'h2730, 1'b0, 1);               // touch ways 0..7
        for (int i = 0; i < 7; i++) do_req({8'(8'h20 + i), 8'h31}, 1'b0, 1);
        do_req(16'h2830, 1'b0, 1);               // evicts clean way 0
        do_req(16'h2035, 1'b0, 0);               // back-to-back hit

        stall_fixed = 5;
        do_req(16'h4476, 1'b1, 1);

        stall_fixed = 0;
        @(negedge clk);
        cpu_addr = 16'h5A94;
        cpu_we = 1'b0;
        cpu_req = 1'b1;
        ref_access(16'h5A94, 1'b0, 1'b0, hit, dm);
        seen = 1'b0;
        n = 0;
        while (!seen && n < 100) begin
            @(negedge clk);
            n++;
            if (mem_req && !mem_we && mem_addr[OW-1:0] == 4'd7) seen = 1'b1;
        end
        check("fill beat 7 reached", seen, 1);
        #3 rst_n = 1'b0;
        #1;
        check("mid-burst reset mem_req", mem_req, 0);
        check("mid-burst reset mem_addr", mem_addr, 0);
        check("mid-burst reset da_fill_we", da_fill_we, 0);
        exp_q.delete();
        cpu_req = 1'b0;
        repeat (2) @(negedge clk);
        #3 rst_n = 1'b1;
        do_req(16'h5A94, 1'b0, 2);               // misses again after reset

        stall_fixed = -1;
        for (int i = 0; i < 80; i++) begin
            t = 8'h80 + 8'($urandom_range(0, 9));
            do_req({t, 4'(10 + $urandom_range(0, 2)), 4'($urandom_range(0, 15))},
                   1'($urandom_range(0, 1)), int'($urandom_range(0, 1)));
        end

        repeat (4) @(negedge clk);
        check("scoreboard drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
